// File: rtl/ctrl_gen.sv
// Control-stream generator: emits start/valid/stop beats on the layer control bus
// with ready backpressure, optional idle gaps between beats, and a done pulse.
module ctrl_gen #(
    parameter int CNT_W = 16,
    parameter int DLY_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [CNT_W-1:0] total,
    input  logic [CNT_W-1:0] interval,
    input  logic [DLY_W-1:0] delay_in,
    output logic             busy,
    output logic             done,
    output logic             ctrl_start,
    output logic             ctrl_valid,
    output logic             ctrl_stop,
    output logic [DLY_W-1:0] ctrl_delay,
    input  logic             ctrl_ready,
    output logic [CNT_W-1:0] beat_idx
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        GAP,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] tot_q;
    logic [CNT_W-1:0] int_q;
    logic [CNT_W-1:0] gap_q;
    logic [CNT_W-1:0] gap_n;
    logic [CNT_W-1:0] idx_n;
    logic [DLY_W-1:0] dly_n;
    logic             load;
    logic             zero_req;
    logic             accept;
    logic             last;

    assign load     = (state == IDLE) && req && (total != '0);
    assign zero_req = (state == IDLE) && req && (total == '0);
    assign accept   = (state == RUN) && ctrl_ready;
    assign last     = (beat_idx == tot_q - 1'b1);

    always_comb begin
        state_n = state;
        gap_n   = gap_q;
        idx_n   = beat_idx;
        dly_n   = ctrl_delay;
        unique case (state)
            IDLE: begin
                idx_n = '0;
                dly_n = '0;
                if (load) begin
                    state_n = START;
                    dly_n   = delay_in;
                end
            end
            START: begin
                state_n = RUN;
                idx_n   = '0;
            end
            RUN: begin
                if (accept) begin
                    if (last) begin
                        state_n = DONE;
                    end else begin
                        idx_n = beat_idx + 1'b1;
                        if (int_q != '0) begin
                            state_n = GAP;
                            gap_n   = int_q;
                        end
                    end
                end
            end
            GAP: begin
                // Leaving on the count of one makes the gap exactly int_q cycles.
                if (gap_q == CNT_W'(1)) begin
                    state_n = RUN;
                end else begin
                    gap_n = gap_q - 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
                idx_n   = '0;
                dly_n   = '0;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tot_q      <= '0;
            int_q      <= '0;
            gap_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ctrl_start <= 1'b0;
            ctrl_valid <= 1'b0;
            ctrl_stop  <= 1'b0;
            ctrl_delay <= '0;
            beat_idx   <= '0;
        end else begin
            state <= state_n;
            gap_q <= gap_n;
            if (load) begin
                tot_q <= total;
                int_q <= interval;
            end
            busy       <= (state_n == START) || (state_n == RUN) || (state_n == GAP);
            done       <= (state_n == DONE) || zero_req;
            ctrl_start <= (state_n == START);
            ctrl_valid <= (state_n == RUN);
            ctrl_stop  <= (state_n == RUN) && (idx_n == tot_q - 1'b1);
            ctrl_delay <= dly_n;
            beat_idx   <= idx_n;
        end
    end

endmodule

// File: tb/tb_ctrl_gen.sv
// Bench for ctrl_gen: per-transaction expected waveform built from beat/gap/stall
// arithmetic, then compared cycle by cycle against the DUT.
module tb_ctrl_gen;

    localparam int CW = 4;
    localparam int DW = 32;
    localparam int N  = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [CW-1:0] total;
    logic [CW-1:0] interval;
    logic [DW-1:0] delay_in;
    logic          busy;
    logic          done;
    logic          ctrl_start;
    logic          ctrl_valid;
    logic          ctrl_stop;
    logic [DW-1:0] ctrl_delay;
    logic          ctrl_ready;
    logic [CW-1:0] beat_idx;

    int checks = 0;
    int failures = 0;

    bit          e_start [N];
    bit          e_valid [N];
    bit          e_stop  [N];
    bit          e_busy  [N];
    bit          e_done  [N];
    int          e_idx   [N];
    logic [31:0] e_dly   [N];
    bit          rdy     [N];

    ctrl_gen #(.CNT_W(CW), .DLY_W(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .total      (total),
        .interval   (interval),
        .delay_in   (delay_in),
        .busy       (busy),
        .done       (done),
        .ctrl_start (ctrl_start),
        .ctrl_valid (ctrl_valid),
        .ctrl_stop  (ctrl_stop),
        .ctrl_delay (ctrl_delay),
        .ctrl_ready (ctrl_ready),
        .beat_idx   (beat_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // rmode: 0 ready always high, 1 random, 2 low on cycles 3..5
    task automatic run_txn(input int tot, input int gap, input logic [31:0] dly,
                           input int rmode, input int rst_at, input bit noise);
        int t;
        int dc;
        int lastc;
        for (int c = 0; c < N; c++) begin
            e_start[c] = 0; e_valid[c] = 0; e_stop[c] = 0;
            e_busy[c] = 0; e_done[c] = 0; e_idx[c] = 0; e_dly[c] = 0;
            case (rmode)
                0: rdy[c] = 1'b1;
                2: rdy[c] = !(c >= 3 && c <= 5);
                default: rdy[c] = (c >= 300) || ($urandom_range(0, 3) != 0);
            endcase
        end
        if (tot == 0) begin
            dc = 1;
        end else begin
            e_start[1] = 1;
            t = 2;
            dc = 0;
            for (int b = 0; b < tot; b++) begin
                while (1) begin
                    e_valid[t] = 1;
                    e_idx[t]   = b;
                    e_stop[t]  = (b == tot - 1);
                    if (rdy[t]) break;
                    t++;
                end
                if (b == tot - 1) dc = t + 1;
                else t = t + 1 + gap;
            end
            for (int c = 1; c < dc; c++) e_busy[c] = 1;
            for (int c = 1; c <= dc; c++) e_dly[c] = dly;
        end
        e_done[dc] = 1;
        lastc = (rst_at > 0) ? rst_at + 1 : dc;
        for (int c = 0; c <= lastc; c++) begin
            @(posedge clk);
            #1;
            rst        = (c == rst_at);
            ctrl_ready = rdy[c];
            if (c == 0) begin
                req      = 1'b1;
                total    = CW'(tot);
                interval = CW'(gap);
                delay_in = dly;
            end else begin
                req = noise && tot != 0 && c <= dc && (rst_at < 0 || c <= rst_at)
                      && ($urandom_range(0, 2) == 0);
                total    = CW'($urandom);
                interval = CW'($urandom);
                delay_in = $urandom;
            end
            @(negedge clk);
            if (rst_at > 0 && c > rst_at) begin
                check("rst_busy",  busy,       0);
                check("rst_done",  done,       0);
                check("rst_start", ctrl_start, 0);
                check("rst_valid", ctrl_valid, 0);
                check("rst_stop",  ctrl_stop,  0);
                check("rst_delay", ctrl_delay, 0);
                check("rst_idx",   beat_idx,   0);
            end else begin
                check($sformatf("start@%0d", c), ctrl_start, e_start[c]);
                check($sformatf("valid@%0d", c), ctrl_valid, e_valid[c]);
                check($sformatf("stop@%0d", c),  ctrl_stop,  e_stop[c]);
                check($sformatf("busy@%0d", c),  busy,       e_busy[c]);
                check($sformatf("done@%0d", c),  done,       e_done[c]);
                check($sformatf("delay@%0d", c), ctrl_delay, e_dly[c]);
                if (e_start[c] || e_valid[c])
                    check($sformatf("idx@%0d", c), beat_idx, e_idx[c]);
            end
        end
        rst = 1'b0;
        req = 1'b0;
    endtask

    initial begin
        int tot;
        int gap;
        int ra;
        rst = 1'b1;
        req = 1'b0;
        total = '0;
        interval = '0;
        delay_in = '0;
        ctrl_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy",  busy,       0);
        check("reset_done",  done,       0);
        check("reset_start", ctrl_start, 0);
        check("reset_valid", ctrl_valid, 0);
        check("reset_stop",  ctrl_stop,  0);
        check("reset_delay", ctrl_delay, 0);
        check("reset_idx",   beat_idx,   0);

        run_txn(4, 0, 7, 0, -1, 0);
        run_txn(3, 2, 32'h55, 0, -1, 0);
        run_txn(3, 0, 32'h1234, 2, -1, 0);
        run_txn(0, 1, 32'hdead, 0, -1, 0);
        run_txn(5, 0, 32'h9, 0, 4, 0);
        run_txn(2, 1, 32'h77, 0, -1, 0);
        run_txn(4, 1, 32'hbeef, 0, -1, 1);
        run_txn(15, 0, 32'hffff_ffff, 1, -1, 0);
        run_txn(1, 3, 32'h1, 1, -1, 1);

        for (int i = 0; i < 60; i++) begin
            tot = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 15);
            gap = $urandom_range(0, 3);
            ra  = -1;
            if (tot != 0 && $urandom_range(0, 4) == 0) ra = $urandom_range(1, 3);
            run_txn(tot, gap, $urandom, 1, ra, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
